// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time,
// configurable wait states, busy stall to the hazard unit, error pulse.
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [2**ADDR_W];

  logic        acc_we;
  logic [3:0]  acc_be;
  logic [31:2] acc_addr;
  logic [31:0] acc_wdata;
  logic        be_legal;
  logic        acc_err;
  logic        enter_done;
  logic        mem_wr;
  logic [ADDR_W-1:0] word_idx;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  // With no wait states the access completes on the accepting edge, so the
  // access path must look at the live inputs rather than the latched copy.
  always_comb begin
    acc_we    = we_q;
    acc_be    = be_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_we    = we;
      acc_be    = be;
      acc_addr  = addr[31:2];
      acc_wdata = wdata;
    end
  end

  always_comb begin
    case (acc_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign word_idx   = acc_addr[ADDR_W+1:2];
  assign acc_err    = (|acc_addr[31:ADDR_W+2]) | (acc_we & ~be_legal);
  assign enter_done = (next_state == DONE) && (state != DONE);
  // A store racing an asserted reset must not reach the array.
  assign mem_wr     = enter_done & acc_we & ~acc_err & reset;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
      WAIT: if (wait_cnt == 4'd0) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy  = (state == WAIT);
  assign ready = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata    <= 32'd0;
      err      <= 1'b0;
    end else begin
      state <= next_state;
      err   <= enter_done & acc_err;
      if (state == IDLE && req) begin
        we_q     <= we;
        be_q     <= be;
        addr_q   <= addr[31:2];
        wdata_q  <= wdata;
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_done && !acc_we) begin
        rdata <= acc_err ? 32'd0 : mem[word_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
